// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Multiplexed 4-digit, 7-segment display scanner with a write port.
//
// Each digit gets a slot of DIV clock cycles. The first DEAD cycles of every
// slot are dark. This dead time stops ghosting when the digit enable moves
// from one digit to the next. The value shown in a slot is captured once, at
// the start of the slot, so a write can never change a digit while it is lit.
//
// Parameters
//   DIV   : clock cycles per digit slot (>= 4)
//   DEAD  : dark cycles at the start of each slot (1 <= DEAD <= DIV-2)
//
// Ports
//   CLK     in   clock; all state changes on its rising edge
//   RST     in   synchronous, active-high reset
//   WR_EN   in   write strobe, one write per high cycle, never back-pressured
//   WR_ADDR in   [1:0] digit index to write
//   WR_DATA in   [4:0] {blank, hex value}; blank=1 keeps the digit dark
//   SEG     out  [6:0] segments abcdefg (a = bit 6), active-high, registered
//   DIG     out  [3:0] one-hot digit enable, active-high, registered
//   FRAME   out  one-cycle pulse at the start of each 4-slot scan frame
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIV  = 50000,
    parameter int DEAD = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_EN,
    input  logic [1:0] WR_ADDR,
    input  logic [4:0] WR_DATA,
    output logic [6:0] SEG,
    output logic [3:0] DIG,
    output logic       FRAME
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
    localparam logic [4:0]    BLANK_ZERO = 5'b10000;

    logic [CW-1:0] cnt;
    logic [1:0]    slot;
    logic [4:0]    digitReg [4];
    logic [4:0]    cur;

    logic [6:0]    segNext;
    logic [3:0]    digNext;
    logic          frameNext;

    // Hex to segment pattern, abcdefg with a at bit 6.
    function automatic logic [6:0] decodeHex(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0: pattern = 7'h7E;
            4'h1: pattern = 7'h30;
            4'h2: pattern = 7'h6D;
            4'h3: pattern = 7'h79;
            4'h4: pattern = 7'h33;
            4'h5: pattern = 7'h5B;
            4'h6: pattern = 7'h5F;
            4'h7: pattern = 7'h70;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h7B;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h1F;
            4'hC: pattern = 7'h4E;
            4'hD: pattern = 7'h3D;
            4'hE: pattern = 7'h4F;
            default: pattern = 7'h47;
        endcase
        return pattern;
    endfunction

    // Digit storage. Writes are always accepted. Reset has priority, so a
    // write in a reset cycle is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                digitReg[i] <= BLANK_ZERO;
            end
        end else if (WR_EN) begin
            digitReg[WR_ADDR] <= WR_DATA;
        end
    end

    // Free-running prescaler and slot counter. cur is loaded once per slot,
    // at cnt==0. The load reads digitReg before any write on the same edge
    // takes effect. A write that collides with the capture therefore shows
    // on the next visit to that slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            slot <= 2'd0;
            cur  <= BLANK_ZERO;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                slot <= slot + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == '0) begin
                cur <= digitReg[slot];
            end
        end
    end

    // Output pattern for the current cycle. The enable stays low during the
    // dead phase and for a blanked digit. DIG therefore always passes through
    // zero between two different digits, and SEG is zero whenever DIG is.
    always_comb begin
        segNext   = 7'h00;
        digNext   = 4'b0000;
        frameNext = (cnt == '0) && (slot == 2'd0);
        if ((cnt >= CNT_DEAD) && !cur[4]) begin
            digNext = 4'b0001 << slot;
            segNext = decodeHex(cur[3:0]);
        end
    end

    // Registered outputs, one cycle behind the counters. This keeps them
    // glitch-free at the pins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG   <= 7'h00;
            DIG   <= 4'b0000;
            FRAME <= 1'b0;
        end else begin
            SEG   <= segNext;
            DIG   <= digNext;
            FRAME <= frameNext;
        end
    end

endmodule
